au_in_sched: RTL and testbench

- Round-robin scheduler for the 7-input, 32-bit arithmetic-unit (AU) input mux. It drives the mux's 3-bit SEL.
- Seven requesters compete for the AU operand path; the block arbitrates among them and holds SEL stable through a valid/ready handshake with the AU.
- It tracks accepted operations through a fixed-latency tag pipeline so each result is steered back to its originator.
- Sits between the requester blocks, MUX_AU_IN and the AU.

---
 rtl/au_in_sched_pkg.sv | 37 +++
 rtl/au_in_sched_if.sv | 27 ++
 rtl/au_in_sched_rr_pick7.sv | 24 ++
 rtl/au_in_sched.sv | 112 +++++++++++
 tb/tb_au_in_sched.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/au_in_sched_pkg.sv
// Shared types and helpers for the AU input scheduler: source index type,
// result tag, FSM states and modulo-7 index arithmetic.
package au_in_sched_pkg;

  localparam int N_AU_SRC       = 7;
  localparam int AU_SEL_W       = 3;
  localparam int AU_LAT_DEFAULT = 4;

  typedef logic [AU_SEL_W-1:0] au_sel_t;
  typedef logic [N_AU_SRC-1:0] au_req_t;

  typedef struct packed {
    logic    valid;
    au_sel_t idx;
  } au_tag_t;

  typedef enum logic {
    IDLE,
    GRANT
  } au_state_t;

  // Adds two source indices and wraps the result back into 0..6.
  function automatic au_sel_t selWrapAdd(au_sel_t a, au_sel_t b);
    logic [AU_SEL_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (AU_SEL_W+1)'(N_AU_SRC)) begin
      sum = sum - (AU_SEL_W+1)'(N_AU_SRC);
    end
    return sum[AU_SEL_W-1:0];
  endfunction

  // Decodes a source index into its one-hot requester bit.
  function automatic au_req_t selOneHot(au_sel_t s);
    return au_req_t'(1) << s;
  endfunction

endpackage

// File: rtl/au_in_sched_if.sv
// Requester/AU-facing bundle of the scheduler. The master side (requesters
// and AU) drives requests, enable and ready; the slave side is the scheduler.
interface au_in_sched_if;
  import au_in_sched_pkg::*;

  logic    en;
  au_req_t req;
  logic    auReady;
  au_sel_t sel;
  logic    auValid;
  au_req_t ack;
  logic    resValid;
  au_sel_t resSel;
  au_req_t done;
  logic    busy;

  modport master (
    output en, req, auReady,
    input  sel, auValid, ack, resValid, resSel, done, busy
  );

  modport slave (
    input  en, req, auReady,
    output sel, auValid, ack, resValid, resSel, done, busy
  );

endinterface

// File: rtl/au_in_sched_rr_pick7.sv
// Rotating priority encoder over seven requesters: returns the first set
// request found searching from ptr upward, wrapping 6 back to 0.
module rr_pick7
  import au_in_sched_pkg::*;
(
  input  au_req_t req_i,
  input  au_sel_t ptr_i,
  output logic    any_o,
  output au_sel_t idx_o
);

  // Walk candidates from lowest to highest priority so the last hit wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = N_AU_SRC-1; k >= 0; k--) begin
      if (req_i[selWrapAdd(ptr_i, au_sel_t'(k))]) begin
        any_o = 1'b1;
        idx_o = selWrapAdd(ptr_i, au_sel_t'(k));
      end
    end
  end

endmodule

// File: rtl/au_in_sched.sv
// Round-robin scheduler driving the AU input mux select. Holds the grant
// stable across the AU valid/ready handshake and tracks accepted operations
// through a fixed-latency tag pipeline so results return to their owner.
module au_in_sched
  import au_in_sched_pkg::*;
#(
  parameter int AU_LAT = AU_LAT_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  au_in_sched_if.slave bus
);

  au_state_t state_q;
  au_sel_t   sel_q;
  au_sel_t   ptr_q;
  au_sel_t   ptr_d;
  au_sel_t   pickIdx;
  logic      auValid_q;
  logic      accept;
  logic      pickAny;
  logic      tagBusy;
  au_req_t   ack_q;
  au_req_t   maskedReq;
  au_tag_t   tagIn_d;
  au_tag_t   tagPipe_q [AU_LAT];

  // The operand being accepted must not win again in its own accept cycle.
  assign accept    = auValid_q & bus.auReady;
  assign maskedReq = accept ? (bus.req & ~selOneHot(sel_q)) : bus.req;
  assign ptr_d     = selWrapAdd(sel_q, au_sel_t'(1));

  assign tagIn_d.valid = accept;
  assign tagIn_d.idx   = accept ? sel_q : '0;

  rr_pick7 u_pick (
    .req_i (maskedReq),
    .ptr_i (ptr_q),
    .any_o (pickAny),
    .idx_o (pickIdx)
  );

  // Grant FSM: issues a select, holds it until accepted, chains grants with no bubble.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      auValid_q <= 1'b0;
      ack_q     <= '0;
    end else begin
      ack_q <= accept ? selOneHot(sel_q) : '0;
      case (state_q)
        IDLE: begin
          if (bus.en && pickAny) begin
            sel_q     <= pickIdx;
            auValid_q <= 1'b1;
            state_q   <= GRANT;
          end else begin
            auValid_q <= 1'b0;
          end
        end
        GRANT: begin
          if (accept) begin
            ptr_q <= ptr_d;
            if (bus.en && pickAny) begin
              sel_q <= pickIdx;
            end else begin
              auValid_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: begin
          auValid_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // Result-owner tags advance one stage per cycle; a reset discards them all.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < AU_LAT; i++) begin
        tagPipe_q[i] <= '0;
      end
    end else begin
      tagPipe_q[0] <= tagIn_d;
      for (int i = 1; i < AU_LAT; i++) begin
        tagPipe_q[i] <= tagPipe_q[i-1];
      end
    end
  end

  // Any valid tag anywhere in the pipeline means work is still in flight.
  always_comb begin
    tagBusy = 1'b0;
    for (int i = 0; i < AU_LAT; i++) begin
      tagBusy = tagBusy | tagPipe_q[i].valid;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.auValid  = auValid_q;
  assign bus.ack      = ack_q;
  assign bus.resValid = tagPipe_q[AU_LAT-1].valid;
  assign bus.resSel   = tagPipe_q[AU_LAT-1].idx;
  assign bus.done     = tagPipe_q[AU_LAT-1].valid ? selOneHot(tagPipe_q[AU_LAT-1].idx) : '0;
  assign bus.busy     = (state_q == GRANT) | tagBusy;

endmodule

// File: tb/tb_au_in_sched.sv
// Directed bench for the AU input scheduler: drives inputs on the falling
// edge, samples outputs on the falling edge after each rising edge.
module tb_au_in_sched;
  import au_in_sched_pkg::*;

  logic clk;
  logic rstN;
  int   total = 0;
  int   bad   = 0;

  au_in_sched_if bus();

  au_in_sched dut (
    .clk_i   (clk),
    .rst_n_i (rstN),
    .bus     (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bound the whole run in case something stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic en, input au_req_t req, input logic ready);
    bus.en      = en;
    bus.req     = req;
    bus.auReady = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    logic [31:0] expAck;

    // Reset state
    rstN = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_sel",      32'(bus.sel),      32'd0);
    checkOutput("rst_auValid",  32'(bus.auValid),  32'd0);
    checkOutput("rst_ack",      32'(bus.ack),      32'd0);
    checkOutput("rst_resValid", 32'(bus.resValid), 32'd0);
    checkOutput("rst_resSel",   32'(bus.resSel),   32'd0);
    checkOutput("rst_done",     32'(bus.done),     32'd0);
    checkOutput("rst_busy",     32'(bus.busy),     32'd0);
    rstN = 1'b1;

    // Single request from source 0, AU always ready
    applyStimulus(1'b1, 7'b0000001, 1'b1);
    nextCycle();
    checkOutput("t1_auValid", 32'(bus.auValid), 32'd1);
    checkOutput("t1_sel",     32'(bus.sel),     32'd0);
    checkOutput("t1_ackEarly",32'(bus.ack),     32'd0);
    checkOutput("t1_busy",    32'(bus.busy),    32'd1);
    nextCycle();
    checkOutput("t1_ack",     32'(bus.ack),     32'b0000001);
    checkOutput("t1_idle",    32'(bus.auValid), 32'd0);
    checkOutput("t1_busyTag", 32'(bus.busy),    32'd1);
    applyStimulus(1'b1, 7'b0000000, 1'b1);
    nextCycle();
    checkOutput("t1_resEarly2", 32'(bus.resValid), 32'd0);
    nextCycle();
    checkOutput("t1_resEarly3", 32'(bus.resValid), 32'd0);
    nextCycle();
    checkOutput("t1_done",     32'(bus.done),     32'b0000001);
    checkOutput("t1_resValid", 32'(bus.resValid), 32'd1);
    checkOutput("t1_resSel",   32'(bus.resSel),   32'd0);
    nextCycle();
    checkOutput("t1_doneOff", 32'(bus.done), 32'd0);
    checkOutput("t1_busyOff", 32'(bus.busy), 32'd0);

    // All sources requesting: strict rotation with no bubble, wrapping 6 -> 0
    doReset();
    applyStimulus(1'b1, 7'b1111111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      checkOutput($sformatf("t2_sel%0d", i),     32'(bus.sel),     32'(i % 7));
      checkOutput($sformatf("t2_auValid%0d", i), 32'(bus.auValid), 32'd1);
      expAck = (i > 0) ? (32'd1 << ((i - 1) % 7)) : 32'd0;
      checkOutput($sformatf("t2_ack%0d", i),     32'(bus.ack),     expAck);
    end
    applyStimulus(1'b1, 7'b0000000, 1'b1);
    nextCycle();
    checkOutput("t2_lastAck", 32'(bus.ack),     32'b0000001);
    checkOutput("t2_idle",    32'(bus.auValid), 32'd0);
    repeat (6) nextCycle();

    // AU stalls: select held on source 2, then next grant goes to source 5
    doReset();
    applyStimulus(1'b1, 7'b0100100, 1'b0);
    nextCycle();
    checkOutput("t3_sel",     32'(bus.sel),     32'd2);
    checkOutput("t3_auValid", 32'(bus.auValid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput($sformatf("t3_holdSel%0d", i),   32'(bus.sel),     32'd2);
      checkOutput($sformatf("t3_holdValid%0d", i), 32'(bus.auValid), 32'd1);
      checkOutput($sformatf("t3_holdAck%0d", i),   32'(bus.ack),     32'd0);
    end
    applyStimulus(1'b1, 7'b0100100, 1'b1);
    nextCycle();
    checkOutput("t3_ack2",   32'(bus.ack),     32'b0000100);
    checkOutput("t3_sel5",   32'(bus.sel),     32'd5);
    checkOutput("t3_chain",  32'(bus.auValid), 32'd1);
    applyStimulus(1'b1, 7'b0100000, 1'b1);
    nextCycle();
    checkOutput("t3_ack5",   32'(bus.ack),     32'b0100000);
    checkOutput("t3_idle",   32'(bus.auValid), 32'd0);
    applyStimulus(1'b1, 7'b0000000, 1'b1);
    repeat (6) nextCycle();

    // Request withdrawn during a grant: the grant still completes
    doReset();
    applyStimulus(1'b1, 7'b0001000, 1'b0);
    nextCycle();
    checkOutput("t4_sel", 32'(bus.sel), 32'd3);
    applyStimulus(1'b1, 7'b0000000, 1'b0);
    nextCycle();
    checkOutput("t4_holdSel",   32'(bus.sel),     32'd3);
    checkOutput("t4_holdValid", 32'(bus.auValid), 32'd1);
    applyStimulus(1'b1, 7'b0000000, 1'b1);
    nextCycle();
    checkOutput("t4_ack",   32'(bus.ack),     32'b0001000);
    checkOutput("t4_idle",  32'(bus.auValid), 32'd0);
    nextCycle();
    checkOutput("t4_noGrant", 32'(bus.auValid), 32'd0);
    checkOutput("t4_ackOff",  32'(bus.ack),     32'd0);
    nextCycle();
    nextCycle();
    checkOutput("t4_done",   32'(bus.done),   32'b0001000);
    checkOutput("t4_resSel", 32'(bus.resSel), 32'd3);
    repeat (3) nextCycle();

    // Enable gating
    doReset();
    applyStimulus(1'b0, 7'b0001000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput($sformatf("t5_gated%0d", i), 32'(bus.auValid), 32'd0);
      checkOutput($sformatf("t5_busy%0d", i),  32'(bus.busy),    32'd0);
    end
    applyStimulus(1'b1, 7'b0001000, 1'b1);
    nextCycle();
    checkOutput("t5_sel",     32'(bus.sel),     32'd3);
    checkOutput("t5_auValid", 32'(bus.auValid), 32'd1);
    nextCycle();
    checkOutput("t5_ack", 32'(bus.ack), 32'b0001000);
    applyStimulus(1'b1, 7'b0000000, 1'b1);
    repeat (6) nextCycle();

    // Asynchronous reset with two operations in flight
    doReset();
    applyStimulus(1'b1, 7'b1111111, 1'b1);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("t6_preSel",  32'(bus.sel),  32'd2);
    checkOutput("t6_preBusy", 32'(bus.busy), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t6_sel",      32'(bus.sel),      32'd0);
    checkOutput("t6_auValid",  32'(bus.auValid),  32'd0);
    checkOutput("t6_ack",      32'(bus.ack),      32'd0);
    checkOutput("t6_resValid", 32'(bus.resValid), 32'd0);
    checkOutput("t6_busy",     32'(bus.busy),     32'd0);
    applyStimulus(1'b1, 7'b0000000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      checkOutput($sformatf("t6_noDone%0d", i), 32'(bus.done), 32'd0);
    end
    applyStimulus(1'b1, 7'b1111111, 1'b1);
    nextCycle();
    checkOutput("t6_ptrReset", 32'(bus.sel),     32'd0);
    checkOutput("t6_regrant",  32'(bus.auValid), 32'd1);
    applyStimulus(1'b1, 7'b0000000, 1'b1);
    repeat (6) nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
